// File: rtl/mem_io_burst.sv
// Burst bridge between a word stream and a byte-wide internal memory.
// Each word is moved one byte per cycle, channel 0 at the lowest address.
module mem_io_burst #(
  parameter int CHANNELS       = 3,
  parameter int MEM_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                                   Mem_Burst_Clk,
  input  logic                                   Mem_Burst_Reset_n,
  input  logic                                   Mem_Burst_Req_Valid,
  output logic                                   Mem_Burst_Req_Ready,
  input  logic                                   Mem_Burst_Req_Sel,
  input  logic [ADDR_WIDTH-1:0]                  Mem_Burst_Start_Addr,
  input  logic [LEN_WIDTH-1:0]                   Mem_Burst_Words,
  input  logic [CHANNELS*MEM_DATA_WIDTH-1:0]     Mem_Burst_Wr_Data,
  input  logic                                   Mem_Burst_Wr_Valid,
  output logic                                   Mem_Burst_Wr_Ready,
  output logic [CHANNELS*MEM_DATA_WIDTH-1:0]     Mem_Burst_Rd_Data,
  output logic                                   Mem_Burst_Rd_Valid,
  input  logic                                   Mem_Burst_Rd_Ready,
  input  logic                                   Mem_Burst_Abort,
  output logic                                   Mem_Burst_Busy,
  output logic                                   Mem_Burst_DNE,
  output logic                                   Mem_Burst_Aborted,
  output logic [LEN_WIDTH-1:0]                   Mem_Burst_Count
);

  localparam int DATA_WIDTH = CHANNELS * MEM_DATA_WIDTH;
  localparam int IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  typedef enum logic [2:0] {
    IDLE, WR_WAIT, WR_BYTE, RD_BYTE, RD_HOLD, DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    words_q, words_d;
  logic [LEN_WIDTH-1:0]    count_q, count_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wr_word_q, wr_word_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    aborted_q, aborted_d;

  // Not reset: contents survive Reset_n.
  logic [MEM_DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic                      mem_we;
  logic [MEM_DATA_WIDTH-1:0] mem_wdata;
  logic [MEM_DATA_WIDTH-1:0] mem_rdata;
  logic                      last_word;

  assign mem_rdata = mem[addr_q];
  assign last_word = (count_q + LEN_WIDTH'(1)) == words_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    words_d   = words_q;
    count_d   = count_q;
    idx_d     = idx_q;
    wr_word_d = wr_word_q;
    rd_data_d = rd_data_q;
    aborted_d = aborted_q;
    mem_we    = 1'b0;
    mem_wdata = wr_word_q[idx_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    unique case (state_q)
      IDLE: begin
        if (Mem_Burst_Req_Valid) begin
          addr_d    = Mem_Burst_Start_Addr;
          words_d   = Mem_Burst_Words;
          count_d   = '0;
          aborted_d = 1'b0;
          idx_d     = '0;
          if (Mem_Burst_Words == '0)  state_d = DONE;
          else if (Mem_Burst_Req_Sel) state_d = RD_BYTE;
          else                        state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (Mem_Burst_Abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (Mem_Burst_Wr_Valid) begin
          wr_word_d = Mem_Burst_Wr_Data;
          idx_d     = '0;
          state_d   = WR_BYTE;
        end
      end
      WR_BYTE: begin
        // Abort suppresses the byte of this cycle; earlier bytes remain.
        if (Mem_Burst_Abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else begin
          mem_we = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            count_d = count_q + LEN_WIDTH'(1);
            state_d = last_word ? DONE : WR_WAIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      RD_BYTE: begin
        if (Mem_Burst_Abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else begin
          rd_data_d[idx_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rdata;
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = RD_HOLD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      RD_HOLD: begin
        // Abort beats a same-cycle Rd_Ready: the held word is not counted.
        if (Mem_Burst_Abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (Mem_Burst_Rd_Ready) begin
          count_d = count_q + LEN_WIDTH'(1);
          state_d = last_word ? DONE : RD_BYTE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Mem_Burst_Clk or negedge Mem_Burst_Reset_n) begin
    if (!Mem_Burst_Reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      words_q   <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      wr_word_q <= '0;
      rd_data_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      words_q   <= words_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      wr_word_q <= wr_word_d;
      rd_data_q <= rd_data_d;
      aborted_q <= aborted_d;
    end
  end

  always_ff @(posedge Mem_Burst_Clk) begin
    if (mem_we) mem[addr_q] <= mem_wdata;
  end

  assign Mem_Burst_Req_Ready = (state_q == IDLE);
  assign Mem_Burst_Busy      = (state_q != IDLE);
  assign Mem_Burst_DNE       = (state_q == DONE);
  assign Mem_Burst_Wr_Ready  = (state_q == WR_WAIT);
  assign Mem_Burst_Rd_Valid  = (state_q == RD_HOLD);
  assign Mem_Burst_Rd_Data   = rd_data_q;
  assign Mem_Burst_Count     = count_q;
  assign Mem_Burst_Aborted   = aborted_q;

endmodule
